// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access controller: access sizes and FSM states.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        SETUP,
        WPULSE,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts a load result from a RAM word and
// merges store data into a RAM word, both purely combinational.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;
    logic [31:0] w_hmask;

    assign w_shifted = i_word >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_offset[1] ? i_word[31:16] : i_word[15:0];
    assign w_bmask   = 32'h0000_00FF << {i_offset, 3'b000};
    assign w_hmask   = i_offset[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;

    always_comb begin
        o_load   = i_word;
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load   = {{24{i_sign_ext & w_byte[7]}}, w_byte};
                // Replicated data lets one mask pick the target lane.
                o_merged = (i_word & ~w_bmask) | ({4{i_wdata[7:0]}} & w_bmask);
            end
            SZ_HALF: begin
                o_load   = {{16{i_sign_ext & w_half[15]}}, w_half};
                o_merged = (i_word & ~w_hmask) | ({2{i_wdata[15:0]}} & w_hmask);
            end
            default: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side load/store controller for a word RAM with an edge-triggered write strobe;
// sub-word stores are done as read-modify-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_WriteMem,
    input  logic [31:0] mem_out
);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_datain;
    logic        r_wstrobe;
    logic        w_err_req;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_err_req = (size == SZ_ILL)
                     | ((size == SZ_HALF) & addr[0])
                     | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
                     | (addr >= 32'(MEM_BYTES));

    mem_lane_align u_lane_align (
        .i_size     (r_size),
        .i_sign_ext (r_sext),
        .i_offset   (r_offset),
        .i_word     (mem_out),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_err_req)                 w_next = DONE;
                    else if (!we)                  w_next = RD;
                    else if (size == SZ_WORD)      w_next = SETUP;
                    else                           w_next = RD;
                end
            end
            RD:      w_next = r_we ? SETUP : DONE;
            SETUP:   w_next = WPULSE;
            WPULSE:  w_next = HOLD;
            HOLD:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_sext       <= 1'b0;
            r_offset     <= 2'b00;
            r_wdata      <= 32'h0;
            r_err        <= 1'b0;
            r_rdata      <= 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_datain <= 32'h0;
            r_wstrobe    <= 1'b0;
        end else begin
            r_state   <= w_next;
            // Registered strobe, high exactly while the FSM sits in WPULSE.
            r_wstrobe <= (w_next == WPULSE);
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we     <= we;
                        r_size   <= size;
                        r_sext   <= sign_ext;
                        r_offset <= addr[1:0];
                        r_wdata  <= wdata;
                        r_err    <= w_err_req;
                        if (!w_err_req) begin
                            r_mem_addr <= {addr[31:2], 2'b00};
                            if (we && (size == SZ_WORD)) r_mem_datain <= wdata;
                        end
                    end
                end
                RD: begin
                    if (r_we) r_mem_datain <= w_merged;
                    else      r_rdata      <= w_load;
                end
                default: ;
            endcase
        end
    end

    assign ready        = (r_state == IDLE);
    assign done         = (r_state == DONE);
    assign err          = (r_state == DONE) & r_err;
    assign rdata        = r_rdata;
    assign mem_addr     = r_mem_addr;
    assign mem_datain   = r_mem_datain;
    assign mem_WriteMem = r_wstrobe;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a word RAM that writes on the strobe's rising edge.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_WriteMem;
    logic [31:0] mem_out;

    logic [31:0] ram [0:255];
    int          wm_count = 0;
    int          errors   = 0;
    int          checks   = 0;
    int          cnt0;

    mem_access_ctrl #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .size         (size),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_WriteMem (mem_WriteMem),
        .mem_out      (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_out = ram[mem_addr[9:2]];

    always @(posedge mem_WriteMem) begin
        ram[mem_addr[9:2]] = mem_datain;
        wm_count = wm_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; checks latency (cycles from accept to done), err and strobe count.
    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input logic exp_err);
        int   lat;
        int   hi;
        int   c0;
        int   ep;
        logic e;
        lat = 0;
        hi  = 0;
        e   = 1'b0;
        c0  = wm_count;
        ep  = (w && !exp_err) ? 1 : 0;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk);
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (mem_WriteMem) hi++;
            if (done) begin
                lat = k;
                e   = err;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        chk({tag, "_wm_hi"}, 32'(hi), 32'(ep));
        chk({tag, "_wm_cnt"}, 32'(wm_count - c0), 32'(ep));
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wm", 32'(mem_WriteMem), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mdin", mem_datain, 32'h0);
        rst = 1'b0;

        run("st_w10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 4, 1'b0);
        chk("ram4_a", ram[4], 32'hDEADBEEF);
        run("ld_w10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 2, 1'b0);
        chk("ld_w10_rdata", rdata, 32'hDEADBEEF);

        run("st_w10b", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 4, 1'b0);
        run("st_b12", 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000AA, 5, 1'b0);
        chk("ram4_b", ram[4], 32'h11AA3344);
        run("st_h10", 1'b1, SZ_HALF, 1'b0, 32'h10, 32'hFFFFBEEF, 5, 1'b0);
        chk("ram4_c", ram[4], 32'h11AABEEF);

        run("st_w10c", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h80FF7F01, 4, 1'b0);
        run("ld_b13s", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 2, 1'b0);
        chk("ld_b13s_rdata", rdata, 32'hFFFFFF80);
        run("ld_h12z", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 2, 1'b0);
        chk("ld_h12z_rdata", rdata, 32'h000080FF);
        run("ld_b11s", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 2, 1'b0);
        chk("ld_b11s_rdata", rdata, 32'h0000007F);
        run("ld_h10s", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 2, 1'b0);
        chk("ld_h10s_rdata", rdata, 32'h00007F01);
        run("ld_b12z", 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 2, 1'b0);
        chk("ld_b12z_rdata", rdata, 32'h000000FF);

        run("e_ld_w11", 1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 1, 1'b1);
        chk("e_ld_w11_rdata", rdata, 32'h000000FF);
        run("e_st_h13", 1'b1, SZ_HALF, 1'b0, 32'h13, 32'h5555, 1, 1'b1);
        chk("e_st_h13_ram", ram[4], 32'h80FF7F01);
        run("e_sz11", 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, 1, 1'b1);
        chk("e_sz11_rdata", rdata, 32'h000000FF);
        run("e_ld_400", 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 1, 1'b1);
        chk("e_ld_400_rdata", rdata, 32'h000000FF);

        run("st_w3fc", 1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'hCAFEF00D, 4, 1'b0);
        run("ld_w3fc", 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 2, 1'b0);
        chk("ld_w3fc_rdata", rdata, 32'hCAFEF00D);

        // Reset while the write strobe is high.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("rw_setup_wm", 32'(mem_WriteMem), 32'd0);
        @(negedge clk);
        chk("rw_wpulse_wm", 32'(mem_WriteMem), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_wm", 32'(mem_WriteMem), 32'd0);
        chk("rw_rst_ready", 32'(ready), 32'd1);
        chk("rw_rst_done", 32'(done), 32'd0);
        chk("rw_rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        chk("rw_ram8", ram[8], 32'h12345678);

        // A request held high through RD and DONE must not start another access.
        cnt0 = wm_count;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        chk("rdreq_ready", 32'(ready), 32'd0);
        we = 1'b1; addr = 32'h24; wdata = 32'h55;
        @(negedge clk);
        chk("rdreq_done", 32'(done), 32'd1);
        chk("rdreq_rdata", rdata, 32'h12345678);
        req = 1'b0;
        @(negedge clk);
        chk("rdreq_idle", 32'(ready), 32'd1);
        chk("rdreq_nodone", 32'(done), 32'd0);
        repeat (6) @(negedge clk);
        chk("rdreq_no_wr", 32'(wm_count - cnt0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
